cellrv32_fifo_unpacker: RTL and testbench

Read-side companion for the generic single-clock FIFO. It drains packed words from a FIFO read port and emits them one lane at a time on a valid/ready stream, least-significant lane first. Each FIFO entry carries a lane-count field, so partially filled words are supported. It sits between TX-side FIFOs (UART/SPI/TWI-style buffers) and byte-oriented serialisers.

---
 rtl/cellrv32_fifo_unpacker.sv | 124 ++++++++++++
 tb/tb_cellrv32_fifo_unpacker.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cellrv32_fifo_unpacker.sv
// ---------------------------------------------------------------------------
// cellrv32_fifo_unpacker
//
// Read-side companion for the generic single-clock FIFO. Pops packed entries
// from a FIFO read port (async-read style: rdata_i is valid together with
// avail_i) and emits them one LANE_WIDTH-bit lane at a time on a valid/ready
// stream, least-significant lane first. Each entry carries a "lanes minus 1"
// count above the payload, so partially filled words are emitted without
// padding lanes.
//
// Ports:
//   clk_i    - clock, rising edge
//   rstn_i   - synchronous reset, active low
//   clear_i  - synchronous abort, drops any entry currently being emitted
//   avail_i  - FIFO holds at least one entry
//   rdata_i  - FIFO head entry: {lane count - 1, payload}
//   re_o     - FIFO pop strobe (only ever high while avail_i is high)
//   lane_o   - current lane data
//   valid_o  - lane_o is valid
//   last_o   - current lane is the final lane of its entry
//   ready_i  - downstream accepts the current lane
//   busy_o   - an entry is held (same as valid_o)
// ---------------------------------------------------------------------------
module cellrv32_fifo_unpacker #(
  parameter  int DATA_WIDTH = 32,
  parameter  int LANE_WIDTH = 8,
  localparam int LANES      = DATA_WIDTH / LANE_WIDTH,
  localparam int CNT_W      = $clog2(LANES)
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        clear_i,
  input  logic                        avail_i,
  input  logic [CNT_W+DATA_WIDTH-1:0] rdata_i,
  output logic                        re_o,
  output logic [LANE_WIDTH-1:0]       lane_o,
  output logic                        valid_o,
  output logic                        last_o,
  input  logic                        ready_i,
  output logic                        busy_o
);

  // Geometry must split evenly into a power-of-two number of lanes so the
  // count field covers exactly 0..LANES-1.
  if ((DATA_WIDTH % LANE_WIDTH) != 0) begin : g_chk_divisible
    $error("cellrv32_fifo_unpacker: DATA_WIDTH must be divisible by LANE_WIDTH");
  end

  if ((LANES < 2) || ((LANES & (LANES - 1)) != 0)) begin : g_chk_lanes
    $error("cellrv32_fifo_unpacker: DATA_WIDTH/LANE_WIDTH must be a power of two >= 2");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   sreg_q,  sreg_d;
  logic [CNT_W-1:0]        rem_q,   rem_d;

  logic                    handshake;
  logic                    rem_zero;
  logic                    load;

  // Handshake and pop decision. A new entry is taken either when idle or in
  // the very cycle the final lane of the current entry is accepted, which is
  // what gives back-to-back entries without a bubble. Reset and clear both
  // block the pop so the FIFO never loses an entry we cannot hold.
  always_comb begin
    handshake = (state_q == SHIFT) & ready_i;
    rem_zero  = (rem_q == '0);
    load      = avail_i & ~clear_i & rstn_i &
                ((state_q == IDLE) | (handshake & rem_zero));
  end

  // State register: every flop of the unpacker lives here.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state logic. clear_i wins over everything; the shift register is
  // left as-is on clear since lane_o is not presented as valid in IDLE.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    rem_d   = rem_q;

    if (clear_i) begin
      state_d = IDLE;
    end else if (load) begin
      state_d = SHIFT;
      sreg_d  = rdata_i[DATA_WIDTH-1:0];
      rem_d   = rdata_i[CNT_W+DATA_WIDTH-1 -: CNT_W];
    end else if (handshake) begin
      if (!rem_zero) begin
        // Payload bits above the counted lanes shift down too, but the
        // entry ends before they can ever reach lane_o as valid data.
        sreg_d = sreg_q >> LANE_WIDTH;
        rem_d  = rem_q - CNT_W'(1);
      end else begin
        state_d = IDLE;
      end
    end
  end

  // Output logic, purely a function of the held state plus the pop strobe.
  always_comb begin
    re_o    = load;
    lane_o  = sreg_q[LANE_WIDTH-1:0];
    valid_o = (state_q == SHIFT);
    last_o  = (state_q == SHIFT) & rem_zero;
    busy_o  = (state_q == SHIFT);
  end

endmodule

// File: tb/tb_cellrv32_fifo_unpacker.sv
// ---------------------------------------------------------------------------
// tb_cellrv32_fifo_unpacker
//
// Bench for the FIFO unpacker with DATA_WIDTH=32, LANE_WIDTH=8. A queue acts
// as the FIFO; whenever the DUT pops an entry, the lanes that entry should
// produce are pushed into an expected-lane queue. A negedge monitor compares
// every presented lane against the head of that queue and drops pending lanes
// on clear or reset.
// ---------------------------------------------------------------------------
module tb_cellrv32_fifo_unpacker;

  localparam int DW = 32;
  localparam int LW = 8;
  localparam int CW = 2;
  localparam int EW = CW + DW;

  logic          clk_i;
  logic          rstn_i;
  logic          clear_i;
  logic          avail_i;
  logic [EW-1:0] rdata_i;
  logic          re_o;
  logic [LW-1:0] lane_o;
  logic          valid_o;
  logic          last_o;
  logic          ready_i;
  logic          busy_o;

  logic [EW-1:0] fifo_q[$];
  logic [LW:0]   exp_q[$];

  int  checks    = 0;
  int  errors    = 0;
  int  pops_req  = 0;
  int  pops_done = 0;
  int  xfers     = 0;
  bit  avail_en  = 1'b1;
  bit  prev_rstn = 1'b1;

  cellrv32_fifo_unpacker #(
    .DATA_WIDTH (DW),
    .LANE_WIDTH (LW)
  ) dut (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .clear_i (clear_i),
    .avail_i (avail_i),
    .rdata_i (rdata_i),
    .re_o    (re_o),
    .lane_o  (lane_o),
    .valid_o (valid_o),
    .last_o  (last_o),
    .ready_i (ready_i),
    .busy_o  (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Present the FIFO head on the read port.
  task automatic refreshFifo();
    avail_i = avail_en && (fifo_q.size() != 0);
    rdata_i = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  // One clock cycle: commit pops seen by the monitor, then drive new inputs.
  task automatic applyStimulus(input bit ready, input bit clear, input bit rstn, input bit en);
    @(posedge clk_i);
    #1;
    while (pops_done < pops_req) begin
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      pops_done++;
    end
    ready_i  = ready;
    clear_i  = clear;
    rstn_i   = rstn;
    avail_en = en;
    refreshFifo();
  endtask

  // Monitor / scoreboard.
  always @(negedge clk_i) begin
    logic [EW-1:0] e;
    int            cnt;
    checkOutput("valid", 32'(valid_o), 32'(exp_q.size() != 0));
    checkOutput("busy", 32'(busy_o), 32'(exp_q.size() != 0));
    if (!avail_i) checkOutput("re_without_avail", 32'(re_o), 32'h0);
    if (clear_i || !rstn_i) checkOutput("re_during_clear_or_reset", 32'(re_o), 32'h0);
    if (!prev_rstn) begin
      checkOutput("lane_after_reset", 32'(lane_o), 32'h0);
      checkOutput("last_after_reset", 32'(last_o), 32'h0);
    end
    if (valid_o && exp_q.size() != 0) begin
      checkOutput("lane", 32'(lane_o), 32'(exp_q[0][LW-1:0]));
      checkOutput("last", 32'(last_o), 32'(exp_q[0][LW]));
      if (ready_i) begin
        void'(exp_q.pop_front());
        xfers++;
      end
    end else begin
      checkOutput("last_while_idle", 32'(last_o), 32'h0);
    end
    if (clear_i || !rstn_i) exp_q.delete();
    if (re_o) begin
      pops_req++;
      if (fifo_q.size() != 0) begin
        e   = fifo_q[0];
        cnt = int'(e[EW-1:DW]);
        for (int i = 0; i <= cnt; i++) exp_q.push_back({(i == cnt), e[i*LW +: LW]});
      end else begin
        checkOutput("pop_from_empty", 32'h1, 32'h0);
      end
    end
    prev_rstn = rstn_i;
  end

  initial begin
    int  p0, x0;
    bit  bp_pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    logic [31:0] rnd_data;
    logic [1:0]  rnd_cnt;
    int  budget;

    rstn_i  = 1'b0;
    clear_i = 1'b0;
    ready_i = 1'b1;
    fifo_q.push_back({2'b11, 32'h44332211});
    refreshFifo();

    // Reset held with data available: nothing popped or emitted.
    p0 = pops_req; x0 = xfers;
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);

    // Full word, ready held high.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("full_pops", 32'(pops_req - p0), 32'd1);
    checkOutput("full_xfers", 32'(xfers - x0), 32'd4);

    // Partial words back to back.
    p0 = pops_req; x0 = xfers;
    fifo_q.push_back({2'b01, 32'hDDCCBBAA});
    fifo_q.push_back({2'b00, 32'h000000EE});
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("partial_pops", 32'(pops_req - p0), 32'd2);
    checkOutput("partial_xfers", 32'(xfers - x0), 32'd3);

    // Backpressure pattern.
    p0 = pops_req; x0 = xfers;
    fifo_q.push_back({2'b11, 32'h44332211});
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    foreach (bp_pat[i]) applyStimulus(bp_pat[i], 1'b0, 1'b1, 1'b1);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("bp_pops", 32'(pops_req - p0), 32'd1);
    checkOutput("bp_xfers", 32'(xfers - x0), 32'd4);

    // Clear mid-entry with a second entry queued.
    p0 = pops_req; x0 = xfers;
    fifo_q.push_back({2'b11, 32'h44332211});
    fifo_q.push_back({2'b11, 32'h88776655});
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (8) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("clear_pops", 32'(pops_req - p0), 32'd2);
    checkOutput("clear_xfers", 32'(xfers - x0), 32'd6);

    // Reset mid-entry.
    p0 = pops_req; x0 = xfers;
    fifo_q.push_back({2'b11, 32'h44332211});
    fifo_q.push_back({2'b11, 32'h88776655});
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (8) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("reset_pops", 32'(pops_req - p0), 32'd2);
    checkOutput("reset_xfers", 32'(xfers - x0), 32'd5);

    // Randomised traffic.
    for (int c = 0; c < 2500; c++) begin
      if (fifo_q.size() < 4 && $urandom_range(0, 2) == 0) begin
        rnd_data = $urandom();
        rnd_cnt  = 2'($urandom_range(0, 3));
        fifo_q.push_back({rnd_cnt, rnd_data});
      end
      applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0,
                    $urandom_range(0, 99) != 0, $urandom_range(0, 9) < 8);
    end

    // Drain everything with a bounded budget.
    budget = 300;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || pops_done != pops_req) && budget > 0) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      budget--;
    end
    if (budget == 0) checkOutput("drain_timeout", 32'h1, 32'h0);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("fifo_drained", 32'(fifo_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
